// File: rtl/sequence_detector_fsm_if.sv
// Symbol stream in, match pulse out, for the fixed 8-symbol pattern detector.
interface sequence_detector_fsm_if;
  logic [2:0] data;
  logic       sequence_found;

  modport master (
    output data,
    input  sequence_found
  );

  modport slave (
    input  data,
    output sequence_found
  );
endinterface

// File: rtl/sequence_detector_fsm.sv
// Detects the symbol pattern 1,5,6,0,6,6,3,5 on a 3-bit stream, with overlap support.
// Emits a registered one-cycle pulse on the edge that samples the final symbol.
module sequence_detector_fsm (
  input  logic                   clk,
  input  logic                   reset_n,
  sequence_detector_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    StMatch0, StMatch1, StMatch2, StMatch3,
    StMatch4, StMatch5, StMatch6, StMatch7
  } state_e;

  state_e state_q, state_d;
  logic   found_q, found_d;

  // Symbol expected next while holding a prefix of the given length.
  function automatic logic [2:0] pattern_sym(state_e s);
    unique case (s)
      StMatch0: pattern_sym = 3'd1;
      StMatch1: pattern_sym = 3'd5;
      StMatch2: pattern_sym = 3'd6;
      StMatch3: pattern_sym = 3'd0;
      StMatch4: pattern_sym = 3'd6;
      StMatch5: pattern_sym = 3'd6;
      StMatch6: pattern_sym = 3'd3;
      StMatch7: pattern_sym = 3'd5;
      default:  pattern_sym = 3'd1;
    endcase
  endfunction

  always_comb begin
    state_d = StMatch0;
    found_d = 1'b0;
    if (bus.data == pattern_sym(state_q)) begin
      if (state_q == StMatch7) begin
        // The final 5 is not a prefix of the pattern, so a match restarts from empty.
        state_d = StMatch0;
        found_d = 1'b1;
      end else begin
        state_d = state_e'(state_q + 3'd1);
      end
    end else if (bus.data == 3'd1) begin
      // 1 only appears at the start of the pattern, so it is the sole fallback prefix.
      state_d = StMatch1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StMatch0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      found_q <= found_d;
    end
  end

  assign bus.sequence_found = found_q;

endmodule

// File: tb/tb_sequence_detector_fsm.sv
// Scoreboard bench: a sliding-window model of the last 8 symbols predicts each pulse.
module tb_sequence_detector_fsm;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  sequence_detector_fsm_if bus ();

  sequence_detector_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         pat [8] = '{1, 5, 6, 0, 6, 6, 3, 5};
  logic [2:0] hist [$];
  logic       exp_q [$];

  // Drive one symbol, predict the output of the coming edge, advance past that edge.
  task automatic apply(input int sym, input logic rst_n);
    logic e;
    @(negedge clk);
    bus.data = 3'(sym);
    reset_n  = rst_n;
    e = 1'b0;
    if (!rst_n) begin
      hist.delete();
    end else begin
      hist.push_back(3'(sym));
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() == 8) begin
        e = 1'b1;
        for (int i = 0; i < 8; i++) if (hist[i] != 3'(pat[i])) e = 1'b0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    for (int i = 0; i < 8; i++) begin
      apply(pat[i], 1'b0);
      e = exp_q.pop_front();
      total++;
      if (bus.sequence_found !== e) begin
        bad++;
        $display("FAIL reset step %0d: got %b want %b", i, bus.sequence_found, e);
      end
    end
  endtask

  task automatic test_seq(input string name, input int syms [$], input int rsts [$],
                          input int want_pulses);
    logic e;
    int   pulses;
    pulses = 0;
    for (int i = 0; i < syms.size(); i++) begin
      apply(syms[i], (i < rsts.size() && rsts[i] == 0) ? 1'b0 : 1'b1);
      e = exp_q.pop_front();
      total++;
      if (bus.sequence_found !== e) begin
        bad++;
        $display("FAIL %s step %0d: got %b want %b", name, i, bus.sequence_found, e);
      end
      if (bus.sequence_found === 1'b1) pulses++;
    end
    total++;
    if (pulses != want_pulses) begin
      bad++;
      $display("FAIL %s pulse count: got %0d want %0d", name, pulses, want_pulses);
    end
  endtask

  task automatic test_clean();
    test_seq("clean", '{1, 5, 6, 0, 6, 6, 3, 5, 0, 0}, '{}, 1);
  endtask

  task automatic test_back_to_back();
    test_seq("back_to_back", '{1, 5, 6, 0, 6, 6, 3, 5, 1, 5, 6, 0, 6, 6, 3, 5, 2}, '{}, 2);
  endtask

  task automatic test_restart();
    test_seq("restart", '{1, 5, 6, 1, 5, 6, 0, 6, 6, 3, 5, 7}, '{}, 1);
  endtask

  task automatic test_near_miss();
    test_seq("near_miss", '{1, 5, 6, 0, 6, 6, 3, 4, 7, 2, 1, 5, 6, 0, 6, 6, 3, 5, 0},
             '{}, 1);
  endtask

  task automatic test_mid_reset();
    test_seq("mid_reset", '{1, 5, 6, 0, 0, 6, 6, 3, 5, 1, 5, 6, 0, 6, 6, 3, 5, 0},
             '{1, 1, 1, 1, 0}, 1);
  endtask

  task automatic test_reset_on_final();
    test_seq("reset_on_final", '{1, 5, 6, 0, 6, 6, 3, 5, 0}, '{1, 1, 1, 1, 1, 1, 1, 0}, 0);
  endtask

  task automatic test_random();
    logic e;
    int   sym;
    for (int i = 0; i < 300; i++) begin
      // Bias towards pattern symbols so matches and partial matches actually occur.
      sym = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                        : pat[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 8; k++) begin
          apply(pat[k], 1'b1);
          e = exp_q.pop_front();
          total++;
          if (bus.sequence_found !== e) begin
            bad++;
            $display("FAIL random inject %0d/%0d: got %b want %b", i, k,
                     bus.sequence_found, e);
          end
        end
      end
      apply(sym, ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      e = exp_q.pop_front();
      total++;
      if (bus.sequence_found !== e) begin
        bad++;
        $display("FAIL random step %0d: got %b want %b", i, bus.sequence_found, e);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    bus.data = 3'd0;
    test_reset();
    test_clean();
    test_back_to_back();
    test_restart();
    test_near_miss();
    test_mid_reset();
    test_reset_on_final();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
